// File: rtl/clock_pkg.sv
// Shared types and field limits for the HH:MM:SS mode controller.
package clock_pkg;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;
   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_HOUR  = 3'd1,
      SET_MIN   = 3'd2,
      SET_SEC   = 3'd3,
      SET_AHOUR = 3'd4,
      SET_AMIN  = 3'd5
   } mode_t;

   // Field +1 with wrap to zero; never carries into the neighbouring field.
   function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
      return (v >= max_v) ? 6'd0 : v + 6'd1;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw button, with a registered rising-edge pulse.
// level is aligned with pulse so a held button can be timed from its edge cycle.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic pulse
);

   logic sync_1;
   logic sync_2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         level  <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_1 <= btn;
         sync_2 <= sync_1;
         level  <= sync_2;
         pulse  <= sync_2 & ~level;
      end
   end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven run/pause and time-set sequencer for the HH:MM:SS counter.
// Optional alarm (SET_AHOUR/SET_AMIN states, alarm_ring) enabled by defining CLOCK_ALARM_EN.
//
// state     | meaning
// RUN       | counter free (running) or paused; btn_run toggles, btn_mode enters edit
// SET_HOUR  | editing load_hour
// SET_MIN   | editing load_min
// SET_SEC   | editing load_sec
// SET_AHOUR | editing alarm hour (alarm build only)
// SET_AMIN  | editing alarm minute (alarm build only)
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int REPEAT_DLY = 50_000_000,
   parameter int REPEAT_PER = 10_000_000
`ifdef CLOCK_ALARM_EN
   , parameter int ALARM_SECS = 60
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              btn_mode,
   input  logic              btn_inc,
   input  logic              btn_run,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   output logic              core_start,
   output logic              core_pause,
   output logic              core_load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MIN_W-1:0]  load_min,
   output logic [SEC_W-1:0]  load_sec,
   output mode_t             mode,
   output logic              blink,
   output logic              alarm_ring
);

   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             mode_p, inc_p, run_p;
   logic             mode_lvl, inc_lvl, run_lvl;
   logic             unused_lvl;
   logic             running;
   logic             start_pend;
   logic             do_inc;
   logic [RPT_W-1:0] rpt_cnt;
   mode_t            edit_next;

   btn_sync_edge u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .level(mode_lvl), .pulse(mode_p));
   btn_sync_edge u_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .level(inc_lvl),  .pulse(inc_p));
   btn_sync_edge u_run  (.clk(clk), .rst(rst), .btn(btn_run),  .level(run_lvl),  .pulse(run_p));

   assign unused_lvl = mode_lvl ^ run_lvl;

`ifdef CLOCK_ALARM_EN
   localparam int ALM_W = $clog2(ALARM_SECS + 1);
   logic [HOUR_W-1:0] alarm_hour;
   logic [MIN_W-1:0]  alarm_min;
   logic [ALM_W-1:0]  alarm_cnt;
   logic              any_p;
   logic              alarm_hit;
   logic              alarm_clr;
   assign any_p     = mode_p | inc_p | run_p;
   assign alarm_hit = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == '0);
   assign alarm_clr = alarm_ring & any_p;
`else
   assign alarm_ring = 1'b0;
`endif

   always_comb begin
      edit_next = RUN;
      case (mode)
         SET_HOUR:  edit_next = SET_MIN;
         SET_MIN:   edit_next = SET_SEC;
`ifdef CLOCK_ALARM_EN
         SET_SEC:   edit_next = SET_AHOUR;
         SET_AHOUR: edit_next = SET_AMIN;
`endif
         default:   edit_next = RUN;
      endcase
   end

   // A mode edge in the same cycle swallows any increment.
   always_comb begin
      do_inc = 1'b0;
      if (mode != RUN && !mode_p)
         do_inc = inc_p | (inc_lvl & (rpt_cnt == RPT_W'(1)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode       <= RUN;
         running    <= 1'b0;
         start_pend <= 1'b0;
         core_start <= 1'b0;
         core_pause <= 1'b0;
         core_load  <= 1'b0;
         load_hour  <= '0;
         load_min   <= '0;
         load_sec   <= '0;
         blink      <= 1'b1;
         rpt_cnt    <= '0;
`ifdef CLOCK_ALARM_EN
         alarm_hour <= '0;
         alarm_min  <= '0;
         alarm_cnt  <= '0;
         alarm_ring <= 1'b0;
`endif
      end else begin
         core_start <= start_pend;
         start_pend <= 1'b0;
         core_pause <= 1'b0;
         core_load  <= 1'b0;
         case (mode)
            RUN: begin
               blink   <= 1'b1;
               rpt_cnt <= '0;
`ifdef CLOCK_ALARM_EN
               if (alarm_clr) begin
                  alarm_ring <= 1'b0;
                  alarm_cnt  <= '0;
               end else
`endif
               if (mode_p) begin
                  mode       <= SET_HOUR;
                  core_pause <= 1'b1;
                  load_hour  <= cur_hour;
                  load_min   <= cur_min;
                  load_sec   <= cur_sec;
               end else if (run_p) begin
                  running <= ~running;
                  if (running)
                     core_pause <= 1'b1;
                  else
                     core_start <= 1'b1;
               end
`ifdef CLOCK_ALARM_EN
               if (!alarm_clr && tick_1hz) begin
                  if (alarm_hit) begin
                     alarm_ring <= 1'b1;
                     alarm_cnt  <= ALM_W'(ALARM_SECS);
                  end else if (alarm_cnt == ALM_W'(1)) begin
                     alarm_ring <= 1'b0;
                     alarm_cnt  <= '0;
                  end else if (alarm_cnt != '0) begin
                     alarm_cnt <= alarm_cnt - ALM_W'(1);
                  end
               end
`endif
            end
            default: begin
               if (mode_p) begin
                  rpt_cnt <= '0;
                  blink   <= 1'b1;
                  mode    <= edit_next;
                  if (edit_next == RUN) begin
                     core_load  <= 1'b1;
                     start_pend <= running;
                  end
               end else begin
                  if (do_inc) begin
                     blink <= 1'b1;
                     case (mode)
                        SET_HOUR:  load_hour  <= HOUR_W'(wrap_inc(6'(load_hour), 6'(HOUR_MAX)));
                        SET_MIN:   load_min   <= wrap_inc(load_min, 6'(MIN_MAX));
                        SET_SEC:   load_sec   <= wrap_inc(load_sec, 6'(SEC_MAX));
`ifdef CLOCK_ALARM_EN
                        SET_AHOUR: alarm_hour <= HOUR_W'(wrap_inc(6'(alarm_hour), 6'(HOUR_MAX)));
                        SET_AMIN:  alarm_min  <= wrap_inc(alarm_min, 6'(MIN_MAX));
`endif
                        default:   mode <= RUN;
                     endcase
                  end else if (tick_1hz) begin
                     blink <= ~blink;
                  end
                  // Repeat timer is armed only by a fresh edge and dies on release.
                  if (inc_p)
                     rpt_cnt <= RPT_W'(REPEAT_DLY);
                  else if (!inc_lvl)
                     rpt_cnt <= '0;
                  else if (rpt_cnt == RPT_W'(1))
                     rpt_cnt <= RPT_W'(REPEAT_PER);
                  else if (rpt_cnt != '0)
                     rpt_cnt <= rpt_cnt - RPT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: a press-level reference model queues expected
// start/pause/load pulses; an independent monitor pops and compares them.
module tb_clock_mode_ctrl;
   import clock_pkg::*;

   localparam int DLY = 8;
   localparam int PER = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       btn_mode, btn_inc, btn_run;
   logic [4:0] cur_hour;
   logic [5:0] cur_min, cur_sec;
   logic       core_start, core_pause, core_load;
   logic [4:0] load_hour;
   logic [5:0] load_min, load_sec;
   mode_t      mode;
   logic       blink, alarm_ring;

   clock_mode_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_run(btn_run),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .core_start(core_start), .core_pause(core_pause), .core_load(core_load),
      .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
      .mode(mode), .blink(blink), .alarm_ring(alarm_ring)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;  // 0 start, 1 pause, 2 load
      int h;
      int m;
      int s;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   // Reference model: one entry per completed button press.
   int  m_state;  // 0 run, 1 hour, 2 min, 3 sec
   bit  m_run;
   int  m_h, m_m, m_s;
   mode_t st_map[4] = '{RUN, SET_HOUR, SET_MIN, SET_SEC};

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push_ev(input int k, input int h, input int m, input int s);
      ev_t e;
      e.kind = k; e.h = h; e.m = m; e.s = s;
      exp_q.push_back(e);
   endtask

   function automatic int n_inc(input int hold);
      if (hold - 1 >= DLY) return 2 + (hold - 1 - DLY) / PER;
      return 1;
   endfunction

   task automatic model_press(input int b, input int hold);
      if (b[0]) begin
         if (m_state == 0) begin
            push_ev(1, 0, 0, 0);
            m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec);
            m_state = 1;
         end else if (m_state == 3) begin
            push_ev(2, m_h, m_m, m_s);
            if (m_run) push_ev(0, 0, 0, 0);
            m_state = 0;
         end else begin
            m_state++;
         end
      end else if (b[1]) begin
         if (m_state != 0) begin
            for (int i = 0; i < n_inc(hold); i++) begin
               if (m_state == 1) m_h = (m_h + 1) % 24;
               else if (m_state == 2) m_m = (m_m + 1) % 60;
               else m_s = (m_s + 1) % 60;
            end
         end
      end else if (b[2]) begin
         if (m_state == 0) begin
            push_ev(m_run ? 1 : 0, 0, 0, 0);
            m_run = !m_run;
         end
      end
   endtask

   task automatic press(input int b, input int hold);
      @(posedge clk); #1;
      btn_mode = b[0]; btn_inc = b[1]; btn_run = b[2];
      repeat (hold) @(posedge clk);
      #1;
      btn_mode = 1'b0; btn_inc = 1'b0; btn_run = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_mode"}, int'(mode), int'(st_map[m_state]));
      check({tag, "_load_hour"}, int'(load_hour), m_h);
      check({tag, "_load_min"}, int'(load_min), m_m);
      check({tag, "_load_sec"}, int'(load_sec), m_s);
      if (m_state == 0) check({tag, "_blink_run"}, int'(blink), 1);
   endtask

   task automatic do_press(input string tag, input int b, input int hold);
      model_press(b, hold);
      press(b, hold);
      check_state(tag);
   endtask

   task automatic model_reset();
      m_state = 0; m_run = 1'b0; m_h = 0; m_m = 0; m_s = 0;
   endtask

   // Monitor: every output pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && (core_start || core_pause || core_load)) begin
         int got;
         ev_t e;
         got = core_load ? 2 : (core_pause ? 1 : 0);
         if ($countones({core_start, core_pause, core_load}) > 1) begin
            errors++;
            $display("FAIL multi_pulse: start=%0b pause=%0b load=%0b", core_start, core_pause, core_load);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d, expected none", got);
         end else begin
            e = exp_q.pop_front();
            if (e.kind != got) begin
               errors++;
               $display("FAIL pulse_kind: got %0d expected %0d", got, e.kind);
            end else if (got == 2 && (int'(load_hour) != e.h || int'(load_min) != e.m ||
                                      int'(load_sec) != e.s)) begin
               errors++;
               $display("FAIL load_value: got %0d:%0d:%0d expected %0d:%0d:%0d",
                        load_hour, load_min, load_sec, e.h, e.m, e.s);
            end
         end
      end
   end

   initial begin
      tick_1hz = 1'b0;
      forever begin
         @(posedge clk); #1;
         tick_1hz = ($urandom_range(0, 6) == 0);
      end
   end

   initial begin
      rst = 1'b1;
      btn_mode = 1'b0; btn_inc = 1'b0; btn_run = 1'b0;
      cur_hour = '0; cur_min = '0; cur_sec = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_start", int'(core_start), 0);
      check("rst_core_pause", int'(core_pause), 0);
      check("rst_core_load", int'(core_load), 0);
      check("rst_alarm_ring", int'(alarm_ring), 0);
      check_state("rst");
      rst = 1'b0;

      // run toggling
      do_press("run_start", 4, 2);
      do_press("run_pause", 4, 2);

      // enter edit while running
      do_press("run_again", 4, 1);
      cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      do_press("enter_edit", 1, 2);

      // three mode edges: load then start on the following cycle
      do_press("to_min", 1, 1);
      do_press("to_sec", 1, 1);
      model_press(1, 2);
      fork
         press(1, 2);
         begin
            int k = 0;
            while (!core_load && k < 20) begin
               @(negedge clk);
               k++;
            end
            check("load_seen", int'(core_load), 1);
            @(negedge clk);
            check("start_after_load", int'(core_start), 1);
         end
      join
      check_state("exit_edit");

      // field wrap boundaries
      cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd0;
      do_press("enter_wrap", 1, 1);
      do_press("hour_wrap", 2, 1);
      check("hour_wrap_zero", int'(load_hour), 0);
      do_press("to_min_wrap", 1, 1);
      do_press("min_wrap", 2, 2);
      check("min_wrap_zero", int'(load_min), 0);

      // mode and inc together: mode wins
      do_press("mode_beats_inc", 3, 3);
      check("min_untouched", int'(load_min), 0);

      // auto-repeat
      do_press("auto_repeat", 2, DLY + 3 * PER);
      check("repeat_sec_4", int'(load_sec), 4);

      // reset mid-edit: nothing pending, edits gone
      check("pending_before_rst", exp_q.size(), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      check_state("after_rst");

      // randomized presses
      for (int n = 0; n < 60; n++) begin
         int r, b, hold;
         r = $urandom_range(0, 9);
         b = (r < 3) ? 1 : ((r < 7) ? 2 : 4);
         hold = (b == 2) ? $urandom_range(1, 26) : $urandom_range(1, 3);
         cur_hour = 5'($urandom_range(0, 23));
         cur_min  = 6'($urandom_range(0, 59));
         cur_sec  = 6'($urandom_range(0, 59));
         do_press("rand", b, hold);
      end

      repeat (10) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
